// File: rtl/z80_io_port_strobe_pkg.sv
// Shared io_board definitions: FSM encoding, Z80 strobe polarity and port map.
package z80_io_port_strobe_pkg;

   typedef enum logic [2:0] {
      ST_ARM    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_READ   = 3'd4
   } state_e;

   localparam logic Z80_ACT   = 1'b0;
   localparam logic Z80_INACT = 1'b1;

   localparam logic [7:0] IO_PORT_LATCH  = 8'h40;
   localparam logic [7:0] IO_PORT_STATUS = 8'h41;
   localparam logic [7:0] IO_PORT_CTRL   = 8'h42;

   localparam int CNT_W = 4;

endpackage

// File: rtl/z80_io_port_strobe_if.sv
// Z80 I/O bus strobes plus the latch/readback control and status flags.
interface z80_io_port_strobe_if;
   logic [7:0] ADDR;
   logic       IORQ_L;
   logic       RD_L;
   logic       WR_L;
   logic       M1_L;
   logic       ACK_H;
   logic       LE_H;
   logic       OE_L;
   logic       WR_PENDING;
   logic       OVERRUN_H;

   modport master (
      output ADDR, IORQ_L, RD_L, WR_L, M1_L, ACK_H,
      input  LE_H, OE_L, WR_PENDING, OVERRUN_H
   );

   modport slave (
      input  ADDR, IORQ_L, RD_L, WR_L, M1_L, ACK_H,
      output LE_H, OE_L, WR_PENDING, OVERRUN_H
   );
endinterface

// File: rtl/z80_io_port_strobe_sync_bit.sv
// Multi-flop synchroniser for one asynchronous bus strobe, with selectable reset value.
module z80_io_port_strobe_sync_bit #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= {SYNC_STAGES{RST_VAL}};
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/z80_io_port_strobe.sv
// Z80 I/O port decoder: synchronised strobes drive a fixed-width LE_H pulse on
// writes and a gated OE_L on reads, with pending-write and overrun flags.
module z80_io_port_strobe
   import z80_io_port_strobe_pkg::*;
#(
   parameter logic [7:0] PORT_ADDR   = IO_PORT_LATCH,
   parameter int         LE_WIDTH    = 2,
   parameter int         SYNC_STAGES = 2
) (
   input logic                  CLK,
   input logic                  RST_H,
   z80_io_port_strobe_if.slave  bus
);

   localparam logic [CNT_W-1:0] LE_LOAD   = CNT_W'(LE_WIDTH - 1);
   localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(SYNC_STAGES);

   logic iorq_s, rd_s, wr_s, m1_s;
   logic addr_hit, io_wr, io_rd;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             le_q, le_d;
   logic             oe_q, oe_d;
   logic             pend_q, pend_d;
   logic             ovr_q, ovr_d;

   z80_io_port_strobe_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(Z80_INACT)) u_sync_iorq (
      .clk_i(CLK), .rst_i(RST_H), .d_i(bus.IORQ_L), .q_o(iorq_s));
   z80_io_port_strobe_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(Z80_INACT)) u_sync_rd (
      .clk_i(CLK), .rst_i(RST_H), .d_i(bus.RD_L), .q_o(rd_s));
   z80_io_port_strobe_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(Z80_INACT)) u_sync_wr (
      .clk_i(CLK), .rst_i(RST_H), .d_i(bus.WR_L), .q_o(wr_s));
   z80_io_port_strobe_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(Z80_INACT)) u_sync_m1 (
      .clk_i(CLK), .rst_i(RST_H), .d_i(bus.M1_L), .q_o(m1_s));

   assign addr_hit = (bus.ADDR == PORT_ADDR);
   assign io_wr = (iorq_s == Z80_ACT) && (wr_s == Z80_ACT) && (rd_s == Z80_INACT) &&
                  (m1_s == Z80_INACT) && addr_hit;
   assign io_rd = (iorq_s == Z80_ACT) && (rd_s == Z80_ACT) && (wr_s == Z80_INACT) &&
                  (m1_s == Z80_INACT) && addr_hit;

   always_ff @(posedge CLK or posedge RST_H) begin
      if (RST_H) begin
         state_q <= ST_ARM;
         cnt_q   <= WARM_LOAD;
         le_q    <= 1'b0;
         oe_q    <= 1'b1;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         le_q    <= le_d;
         oe_q    <= oe_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      le_d    = le_q;
      oe_d    = oe_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      if (bus.ACK_H) begin
         pend_d = 1'b0;
         ovr_d  = 1'b0;
      end
      case (state_q)
         // The synchronisers restart at inactive after reset, so ARM waits for
         // them to refill before judging whether a bus cycle is still running.
         ST_ARM: begin
            if (cnt_q != '0)             cnt_d   = cnt_q - 4'd1;
            else if (!io_wr && !io_rd)   state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (io_wr) begin
               state_d = ST_STROBE;
               le_d    = 1'b1;
               cnt_d   = LE_LOAD;
               pend_d  = 1'b1;
               ovr_d   = bus.ACK_H ? 1'b0 : (ovr_q | pend_q);
            end else if (io_rd) begin
               state_d = ST_READ;
               oe_d    = 1'b0;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               le_d    = 1'b0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (!io_wr) state_d = ST_IDLE;
         end
         ST_READ: begin
            if (!io_rd) begin
               oe_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_ARM;
            le_d    = 1'b0;
            oe_d    = 1'b1;
         end
      endcase
   end

   assign bus.LE_H       = le_q;
   assign bus.OE_L       = oe_q;
   assign bus.WR_PENDING = pend_q;
   assign bus.OVERRUN_H  = ovr_q;

endmodule

// File: tb/tb_z80_io_port_strobe.sv
// Directed bench for z80_io_port_strobe: default instance plus an LE_WIDTH=4 instance.
module tb_z80_io_port_strobe;

   logic       CLK;
   logic       RST_H;
   logic [7:0] addr;
   logic       iorq_l, rd_l, wr_l, m1_l, ack;
   int         checks;
   int         errors;

   z80_io_port_strobe_if bus0 ();
   z80_io_port_strobe_if bus1 ();

   assign bus0.ADDR = addr;   assign bus1.ADDR = addr;
   assign bus0.IORQ_L = iorq_l; assign bus1.IORQ_L = iorq_l;
   assign bus0.RD_L = rd_l;   assign bus1.RD_L = rd_l;
   assign bus0.WR_L = wr_l;   assign bus1.WR_L = wr_l;
   assign bus0.M1_L = m1_l;   assign bus1.M1_L = m1_l;
   assign bus0.ACK_H = ack;   assign bus1.ACK_H = ack;

   z80_io_port_strobe #(.PORT_ADDR(8'h40), .LE_WIDTH(2), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST_H(RST_H), .bus(bus0));

   z80_io_port_strobe #(.PORT_ADDR(8'h40), .LE_WIDTH(4), .SYNC_STAGES(2)) dut_w4 (
      .CLK(CLK), .RST_H(RST_H), .bus(bus1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_idle();
      iorq_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1; m1_l = 1'b1;
   endtask

   task automatic test_reset();
      addr = 8'h00; ack = 1'b0; bus_idle();
      RST_H = 1'b1;
      #3;
      checks++; if (bus0.LE_H !== 1'b0) begin errors++; $display("FAIL reset_le actual=%b expected=0", bus0.LE_H); end
      checks++; if (bus0.OE_L !== 1'b1) begin errors++; $display("FAIL reset_oe actual=%b expected=1", bus0.OE_L); end
      checks++; if (bus0.WR_PENDING !== 1'b0) begin errors++; $display("FAIL reset_pend actual=%b expected=0", bus0.WR_PENDING); end
      checks++; if (bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL reset_ovr actual=%b expected=0", bus0.OVERRUN_H); end
      tick();
      RST_H = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_port_write();
      logic exp_le;
      addr = 8'h40; iorq_l = 1'b0; wr_l = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_le = (i == 3 || i == 4);
         checks++; if (bus0.LE_H !== exp_le) begin errors++; $display("FAIL wr_le cyc%0d actual=%b expected=%b", i, bus0.LE_H, exp_le); end
         checks++; if (bus0.OE_L !== 1'b1) begin errors++; $display("FAIL wr_oe cyc%0d actual=%b expected=1", i, bus0.OE_L); end
      end
      bus_idle();
      repeat (3) tick();
      checks++; if (bus0.WR_PENDING !== 1'b1) begin errors++; $display("FAIL wr_pend actual=%b expected=1", bus0.WR_PENDING); end
      checks++; if (bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL wr_ovr actual=%b expected=0", bus0.OVERRUN_H); end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (bus0.WR_PENDING !== 1'b0) begin errors++; $display("FAIL wr_ack_pend actual=%b expected=0", bus0.WR_PENDING); end
      tick();
   endtask

   task automatic test_no_decode();
      addr = 8'h41; iorq_l = 1'b0; wr_l = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++; if (bus0.LE_H !== 1'b0 || bus0.OE_L !== 1'b1) begin errors++; $display("FAIL wrong_addr cyc%0d le=%b oe=%b expected le=0 oe=1", i, bus0.LE_H, bus0.OE_L); end
      end
      bus_idle(); repeat (3) tick();
      addr = 8'h40; iorq_l = 1'b0; m1_l = 1'b0; rd_l = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++; if (bus0.LE_H !== 1'b0 || bus0.OE_L !== 1'b1) begin errors++; $display("FAIL intack cyc%0d le=%b oe=%b expected le=0 oe=1", i, bus0.LE_H, bus0.OE_L); end
      end
      rd_l = 1'b1; wr_l = 1'b0;
      repeat (4) tick();
      checks++; if (bus0.LE_H !== 1'b0) begin errors++; $display("FAIL intack_wr_le actual=%b expected=0", bus0.LE_H); end
      bus_idle(); repeat (3) tick();
      checks++; if (bus0.WR_PENDING !== 1'b0 || bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL nodec_flags pend=%b ovr=%b expected 0 0", bus0.WR_PENDING, bus0.OVERRUN_H); end
   endtask

   task automatic test_port_read();
      logic exp_oe;
      addr = 8'h40; iorq_l = 1'b0; rd_l = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 5) bus_idle();
         exp_oe = !(i >= 3 && i <= 7);
         checks++; if (bus0.OE_L !== exp_oe) begin errors++; $display("FAIL rd_oe cyc%0d actual=%b expected=%b", i, bus0.OE_L, exp_oe); end
         checks++; if (bus0.LE_H !== 1'b0) begin errors++; $display("FAIL rd_le cyc%0d actual=%b expected=0", i, bus0.LE_H); end
      end
      repeat (2) tick();
   endtask

   task automatic do_write(input bit ack_coinc);
      addr = 8'h40; iorq_l = 1'b0; wr_l = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (ack_coinc && i == 3) ack = 1'b1;
         tick();
         ack = 1'b0;
      end
      bus_idle();
      repeat (3) tick();
   endtask

   task automatic test_overrun();
      do_write(1'b0);
      checks++; if (bus0.WR_PENDING !== 1'b1 || bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL ovr_first pend=%b ovr=%b expected 1 0", bus0.WR_PENDING, bus0.OVERRUN_H); end
      do_write(1'b0);
      checks++; if (bus0.OVERRUN_H !== 1'b1) begin errors++; $display("FAIL ovr_second actual=%b expected=1", bus0.OVERRUN_H); end
      do_write(1'b1);
      checks++; if (bus0.WR_PENDING !== 1'b1 || bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL ovr_coinc_ack pend=%b ovr=%b expected 1 0", bus0.WR_PENDING, bus0.OVERRUN_H); end
      do_write(1'b0);
      checks++; if (bus0.OVERRUN_H !== 1'b1) begin errors++; $display("FAIL ovr_again actual=%b expected=1", bus0.OVERRUN_H); end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (bus0.WR_PENDING !== 1'b0 || bus0.OVERRUN_H !== 1'b0) begin errors++; $display("FAIL ovr_ack pend=%b ovr=%b expected 0 0", bus0.WR_PENDING, bus0.OVERRUN_H); end
      tick();
   endtask

   task automatic test_short_write();
      logic exp_le4, exp_le2;
      addr = 8'h40; iorq_l = 1'b0; wr_l = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 3) bus_idle();
         exp_le4 = (i >= 3 && i <= 6);
         exp_le2 = (i == 3 || i == 4);
         checks++; if (bus1.LE_H !== exp_le4) begin errors++; $display("FAIL short_le_w4 cyc%0d actual=%b expected=%b", i, bus1.LE_H, exp_le4); end
         checks++; if (bus0.LE_H !== exp_le2) begin errors++; $display("FAIL short_le_w2 cyc%0d actual=%b expected=%b", i, bus0.LE_H, exp_le2); end
      end
      ack = 1'b1; tick(); ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_strobe();
      logic exp_le;
      addr = 8'h40; iorq_l = 1'b0; wr_l = 1'b0;
      repeat (3) tick();
      checks++; if (bus0.LE_H !== 1'b1) begin errors++; $display("FAIL mid_pre_le actual=%b expected=1", bus0.LE_H); end
      #2 RST_H = 1'b1;
      #1;
      checks++; if (bus0.LE_H !== 1'b0) begin errors++; $display("FAIL mid_async_le actual=%b expected=0", bus0.LE_H); end
      checks++; if (bus1.LE_H !== 1'b0) begin errors++; $display("FAIL mid_async_le_w4 actual=%b expected=0", bus1.LE_H); end
      tick();
      RST_H = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++; if (bus0.LE_H !== 1'b0 || bus1.LE_H !== 1'b0) begin errors++; $display("FAIL mid_no_restrobe cyc%0d le=%b le_w4=%b expected 0 0", i, bus0.LE_H, bus1.LE_H); end
      end
      bus_idle();
      repeat (4) tick();
      iorq_l = 1'b0; wr_l = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         exp_le = (i == 3 || i == 4);
         checks++; if (bus0.LE_H !== exp_le) begin errors++; $display("FAIL mid_new_write cyc%0d actual=%b expected=%b", i, bus0.LE_H, exp_le); end
      end
      checks++; if (bus0.WR_PENDING !== 1'b1) begin errors++; $display("FAIL mid_new_pend actual=%b expected=1", bus0.WR_PENDING); end
      bus_idle();
      repeat (3) tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST_H  = 1'b1;
      test_reset();
      test_port_write();
      test_no_decode();
      test_port_read();
      test_overrun();
      test_short_write();
      test_reset_mid_strobe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
